// File: rtl/motion_vector_select_if.sv
// motion_vector_select_if
// Groups the candidate stream, the result/done handshake and the debug taps
// of motion_vector_select into one bundle.
//   slave  : seen by motion_vector_select (candidates in, result out)
//   master : seen by the producer/consumer side (candidates out, result in)
// Signals:
//   start       level, high for the whole search
//   comp_start  candidate valid; dist_in/vector_x/vector_y form one candidate
//   pe_ready    PE index code, debug capture only
//   dist_in     unsigned candidate distance
//   vector_x/y  two's-complement candidate offsets
//   best_dist   running/final minimum distance
//   motion_x/y  offsets of the best candidate
//   busy        high while collecting candidates
//   done        result valid, held until ack
//   ack         consumer acknowledge of done
//   early_exit  search ended on a zero-distance candidate
//   state_dbg   current FSM state
//   pe_dbg      pe_ready code captured with the last accepted candidate
interface motion_vector_select_if #(
  parameter int DIST_W = 8
);
  logic              start;
  logic              comp_start;
  logic [3:0]        pe_ready;
  logic [DIST_W-1:0] dist_in;
  logic [3:0]        vector_x;
  logic [3:0]        vector_y;
  logic [DIST_W-1:0] best_dist;
  logic [3:0]        motion_x;
  logic [3:0]        motion_y;
  logic              busy;
  logic              done;
  logic              ack;
  logic              early_exit;
  logic [1:0]        state_dbg;
  logic [3:0]        pe_dbg;

  modport slave (
    input  start, comp_start, pe_ready, dist_in, vector_x, vector_y, ack,
    output best_dist, motion_x, motion_y, busy, done, early_exit,
           state_dbg, pe_dbg
  );

  modport master (
    output start, comp_start, pe_ready, dist_in, vector_x, vector_y, ack,
    input  best_dist, motion_x, motion_y, busy, done, early_exit,
           state_dbg, pe_dbg
  );
endinterface

// File: rtl/motion_vector_select.sv
// motion_vector_select
// Tracks the minimum of a stream of candidate distances during a block-match
// search, latches the motion vector of the best candidate, and hands the
// winner to the downstream store with a done/ack handshake.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      motion_vector_select_if.slave (candidate stream, result, debug)
// Optional feature macro: ZERO_EARLY_EXIT_EN -- a winning zero-distance
// candidate ends the search immediately and sets early_exit.
//
// Handshake semantics: a candidate is transferred on every rising edge in
// COLLECT where comp_start=1 (the block is always ready while busy). The
// result is transferred on the edge where done=1 and ack=1; done stays high
// and the result stays frozen until that edge.
module motion_vector_select #(
  parameter int DIST_W   = 8,
  parameter int NUM_CAND = 256,
  parameter int CNT_W    = 9
) (
  input  logic                   clock,
  input  logic                   reset_n,
  motion_vector_select_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAND - 1);

  state_t            state_q;
  logic [DIST_W-1:0] best_q;
  logic [3:0]        mx_q;
  logic [3:0]        my_q;
  logic              busy_q;
  logic              done_q;
  logic              early_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        pe_q;

  logic win;
  logic last_acc;
  logic zero_hit;

  // Strict compare: ties keep the earlier candidate, and an all-ones
  // distance can never displace the all-ones starting value.
  assign win      = bus.dist_in < best_q;
  assign last_acc = (cnt_q == LAST_CNT);

`ifdef ZERO_EARLY_EXIT_EN
  assign zero_hit = win && (bus.dist_in == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      best_q  <= '1;
      mx_q    <= '0;
      my_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      early_q <= 1'b0;
      cnt_q   <= '0;
      pe_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          best_q  <= '1;
          mx_q    <= '0;
          my_q    <= '0;
          cnt_q   <= '0;
          early_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          if (bus.start) begin
            state_q <= COLLECT;
            busy_q  <= 1'b1;
          end
        end

        COLLECT: begin
          if (!bus.start) begin
            // Abort: discard the partial result so IDLE shows the reset view.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            best_q  <= '1;
            mx_q    <= '0;
            my_q    <= '0;
            cnt_q   <= '0;
          end else if (bus.comp_start) begin
            pe_q <= bus.pe_ready;
            if (win) begin
              best_q <= bus.dist_in;
              mx_q   <= bus.vector_x;
              my_q   <= bus.vector_y;
            end
            if (last_acc || zero_hit) begin
              // The final candidate's compare lands on this same edge.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              early_q <= zero_hit;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        DONE: begin
          if (bus.ack) begin
            // Always pass through IDLE, even if start is still high.
            state_q <= IDLE;
            done_q  <= 1'b0;
            best_q  <= '1;
            mx_q    <= '0;
            my_q    <= '0;
            early_q <= 1'b0;
            cnt_q   <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.best_dist  = best_q;
  assign bus.motion_x   = mx_q;
  assign bus.motion_y   = my_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.early_exit = early_q;
  assign bus.state_dbg  = state_q;
  assign bus.pe_dbg     = pe_q;

endmodule

// File: tb/tb_motion_vector_select.sv
module tb_motion_vector_select;
  localparam int DIST_W   = 8;
  localparam int NUM_CAND = 256;
  localparam int W        = DIST_W + 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  motion_vector_select_if #(.DIST_W(DIST_W)) bus();

  motion_vector_select #(
    .DIST_W  (DIST_W),
    .NUM_CAND(NUM_CAND),
    .CNT_W   (9)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- stimulus storage / scoreboard ----------------
  logic [DIST_W-1:0] cand_dist [NUM_CAND];
  logic [3:0]        cand_x    [NUM_CAND];
  logic [3:0]        cand_y    [NUM_CAND];
  logic [W-1:0]      exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.comp_start = 1'b0;
    bus.pe_ready   = 4'h0;
    bus.dist_in    = '0;
    bus.vector_x   = 4'h0;
    bus.vector_y   = 4'h0;
    bus.ack        = 1'b0;
  endtask

  task automatic drive_cand(input int i);
    bus.comp_start = 1'b1;
    bus.dist_in    = cand_dist[i];
    bus.vector_x   = cand_x[i];
    bus.vector_y   = cand_y[i];
    bus.pe_ready   = 4'($urandom_range(15, 0));
  endtask

  // Invalid cycle carrying tempting garbage (a zero distance) that must be ignored.
  task automatic drive_gap();
    bus.comp_start = 1'b0;
    bus.dist_in    = '0;
    bus.vector_x   = 4'($urandom_range(15, 0));
    bus.vector_y   = 4'($urandom_range(15, 0));
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < NUM_CAND; i++) begin
      cand_dist[i] = DIST_W'($urandom_range(hi, lo));
      cand_x[i]    = 4'($urandom_range(15, 0));
      cand_y[i]    = 4'($urandom_range(15, 0));
    end
  endtask

  // ---------------- reference model ----------------
  // Walk the candidate list in arrival order: the first strictly smaller
  // distance wins; with the early-exit build the first zero ends the search.
  task automatic model(output int last, output bit ee);
    int best;
    logic [3:0] bx, by;
    best = (1 << DIST_W) - 1;
    bx = 4'h0;
    by = 4'h0;
    last = NUM_CAND - 1;
    ee = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (int'(cand_dist[i]) < best) begin
        best = int'(cand_dist[i]);
        bx = cand_x[i];
        by = cand_y[i];
      end
`ifdef ZERO_EARLY_EXIT_EN
      if (cand_dist[i] == 0) begin
        last = i;
        ee = 1'b1;
        break;
      end
`endif
    end
    exp_q.push_back({DIST_W'(best), bx, by});
  endtask

  // ---------------- full search with checks ----------------
  task automatic do_search(input string tag, input bit gaps, input bit ack_with_start);
    int last;
    bit ee;
    logic [W-1:0] exp_res;
    logic [W-1:0] got;
    model(last, ee);
    bus.start = 1'b1;
    bus.comp_start = 1'b0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL %s enter_collect: busy=%b done=%b required busy=1 done=0", tag, bus.busy, bus.done);
    end
    for (int i = 0; i <= last; i++) begin
      if (gaps && $urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          drive_gap();
          tick();
        end
      end
      drive_cand(i);
      tick();
      n_vec++;
      if (bus.done !== (i == last)) begin
        n_err++;
        $display("FAIL %s done_timing cand %0d: done=%b required %b", tag, i, bus.done, (i == last));
      end
    end
    bus.comp_start = 1'b0;
    exp_res = exp_q.pop_front();
    got = {bus.best_dist, bus.motion_x, bus.motion_y};
    n_vec++;
    if (got !== exp_res) begin
      n_err++;
      $display("FAIL %s result: dist/x/y=%h required %h", tag, got, exp_res);
    end
    n_vec++;
    if (bus.busy !== 1'b0 || bus.early_exit !== ee) begin
      n_err++;
      $display("FAIL %s done_flags: busy=%b early_exit=%b required busy=0 early_exit=%b", tag, bus.busy, bus.early_exit, ee);
    end
    // Held in DONE without ack, with junk candidates on the bus.
    bus.start = 1'b0;
    repeat (3) begin
      bus.comp_start = 1'b1;
      bus.dist_in = '0;
      bus.vector_x = 4'($urandom_range(15, 0));
      tick();
      got = {bus.best_dist, bus.motion_x, bus.motion_y};
      n_vec++;
      if (bus.done !== 1'b1 || got !== exp_res) begin
        n_err++;
        $display("FAIL %s hold: done=%b dist/x/y=%h required done=1 %h", tag, bus.done, got, exp_res);
      end
    end
    bus.comp_start = 1'b0;
    bus.ack = 1'b1;
    bus.start = ack_with_start;
    tick();
    bus.ack = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.best_dist !== {DIST_W{1'b1}}) begin
      n_err++;
      $display("FAIL %s ack_to_idle: done=%b busy=%b best=%h required 0 0 ff", tag, bus.done, bus.busy, bus.best_dist);
    end
    if (ack_with_start) begin
      tick();
      n_vec++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s idle_then_collect: busy=%b required 1", tag, bus.busy);
      end
      bus.start = 1'b0;
      tick();
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL %s drop_start: busy=%b done=%b required 0 0", tag, bus.busy, bus.done);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.best_dist !== 8'hFF || bus.motion_x !== 4'h0 || bus.motion_y !== 4'h0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.early_exit !== 1'b0) begin
      n_err++;
      $display("FAIL reset: best=%h x=%h y=%h busy=%b done=%b ee=%b required ff 0 0 0 0 0",
               bus.best_dist, bus.motion_x, bus.motion_y, bus.busy, bus.done, bus.early_exit);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fill_random(0, 0);
    for (int i = 0; i < NUM_CAND; i++) cand_dist[i] = 8'd200;
    cand_dist[37] = 8'd5;
    cand_x[37] = 4'hD;
    cand_y[37] = 4'h2;
    do_search("basic", 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    fill_random(0, 0);
    for (int i = 0; i < NUM_CAND; i++) cand_dist[i] = 8'd50;
    cand_dist[10] = 8'd7;
    cand_x[10] = 4'h3;
    cand_y[10] = 4'hA;
    cand_dist[200] = 8'd7;
    cand_x[200] = 4'h9;
    cand_y[200] = 4'h5;
    do_search("tie", 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    fill_random(1, 255);
    do_search("gaps", 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    fill_random(1, 255);
    cand_dist[3] = 8'd1;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      drive_cand(i);
      tick();
    end
    bus.comp_start = 1'b0;
    bus.start = 1'b0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.best_dist !== 8'hFF) begin
      n_err++;
      $display("FAIL abort: busy=%b done=%b best=%h required 0 0 ff", bus.busy, bus.done, bus.best_dist);
    end
    fill_random(10, 255);
    cand_dist[$urandom_range(NUM_CAND - 1, 0)] = 8'd9;
    do_search("abort_restart", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_random(1, 255);
    cand_dist[0] = 8'd3;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 150; i++) begin
      drive_cand(i);
      tick();
    end
    reset_n = 1'b0;
    #2;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.best_dist !== 8'hFF ||
        bus.motion_x !== 4'h0 || bus.motion_y !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b best=%h x=%h y=%h required 0 0 ff 0 0",
               bus.busy, bus.done, bus.best_dist, bus.motion_x, bus.motion_y);
    end
    drive_idle();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_zero_handshake();
    fill_random(1, 255);
    cand_dist[20] = 8'd0;
    cand_x[20] = 4'h8;
    cand_y[20] = 4'h7;
    do_search("zero_handshake", 1'b0, 1'b1);
  endtask

  task automatic test_all_ones();
    fill_random(0, 0);
    for (int i = 0; i < NUM_CAND; i++) cand_dist[i] = 8'hFF;
    do_search("all_ones", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_random(0, 255);
      do_search("random", r[0], 1'b0);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_tie();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_zero_handshake();
    test_all_ones();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/motion_vector_select.md
Name: motion_vector_select

Overview:
- Receives the candidate distance stream that the motion-estimator control and PE array produce once comparison starts.
- Keeps a running minimum of the candidate distances.
- Latches the motion vector (vector_x, vector_y) of the best candidate.
- When the search window is exhausted, presents the winning vector and distance with a done handshake to the downstream frame/vector store.

Parameters:
- DIST_W, 8, width of the candidate distance and of best_dist.
- NUM_CAND, 256, number of candidates per search (16x16 offsets).
- CNT_W, 9, width of the internal candidate counter; must hold NUM_CAND.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level; high for the whole search, low returns to IDLE.
- comp_start  in  1  candidate-valid qualifier; when high, dist_in/vector_x/vector_y are one candidate.
- pe_ready  in  4  PE index code from control; captured for debug only, no functional effect.
- dist_in  in  DIST_W  distance of the current candidate (unsigned).
- vector_x  in  4  two's-complement X offset of the current candidate, range -8..7.
- vector_y  in  4  two's-complement Y offset of the current candidate.
- best_dist  out  DIST_W  minimum distance so far / final.
- motion_x  out  4  X offset of best candidate.
- motion_y  out  4  Y offset of best candidate.
- busy  out  1  high in COLLECT.
- done  out  1  high in DONE, held until ack.
- ack  in  1  consumer acknowledge of done.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, best_dist=all ones, motion_x=0, motion_y=0, busy=0, done=0, counter=0.
  - Reset asserted mid-search aborts immediately; no partial result is ever flagged.
- States:
  - IDLE: best_dist=all ones, motion=0, counter=0.
    - start=1 -> COLLECT on the next edge.
  - COLLECT: busy=1. Each cycle with comp_start=1 is one accepted candidate; the counter increments.
    - If dist_in < best_dist (strict, unsigned), register best_dist=dist_in, motion_x=vector_x, motion_y=vector_y on that edge.
    - Ties keep the earlier candidate.
    - comp_start=0 cycles are ignored: no count, no update.
    - When the NUM_CANDth candidate is accepted (counter reaches NUM_CAND-1 and comp_start=1), the compare for that candidate is still applied on the same edge, then the state goes -> DONE.
    - start=0 while in COLLECT -> IDLE and the result is discarded; done is not asserted.
  - DONE: done=1, busy=0, outputs frozen; comp_start is ignored.
    - ack=1 -> IDLE next edge; done drops the same edge.
    - If ack=1 and start=1 on the same cycle, the block still passes through IDLE for one cycle before entering COLLECT.
    - start=0 without ack stays in DONE; the result is held.
- Latency: results are valid on the cycle done first reads 1, which is one edge after the last candidate is accepted.
- Outputs update only on clock edges; no combinational input-to-output paths.
- Counter width CNT_W; counter is cleared on entry to COLLECT. No wrap: it never exceeds NUM_CAND-1.
- All-ones distance candidates: if every candidate equals all ones, no update occurs. Result is best_dist=all ones, motion=0.

Optional Feature:
- Macro ZERO_EARLY_EXIT_EN.
- Defined:
  - A candidate accepted with dist_in==0 that wins the compare also causes COLLECT -> DONE on that edge, whatever the counter value.
  - Remaining candidates are ignored.
  - A sticky output early_exit (1 bit, reset 0, cleared in IDLE) reads 1 in DONE.
- Undefined:
  - No early exit; the full NUM_CAND candidates are always consumed.
  - early_exit is tied 0.

Test Plan:
- Basic search: reset, start=1, 256 candidates with dist=200 except candidate 37 (vx=-3, vy=2) dist=5 -> done=1 exactly one edge after the 256th accept, best_dist=5, motion_x=4'hD, motion_y=4'h2.
- Tie: candidates 10 and 200 both dist=7, others 50 -> motion equals candidate 10 vector.
- Gaps: comp_start deasserted for random cycles between 256 valid candidates -> done only after the 256th valid candidate; the count ignores gaps.
- Abort: start dropped after 100 candidates, then restarted with a new 256-candidate set whose minimum is 9 -> result reflects the new set only; best_dist=9.
- Reset mid-operation: reset_n pulsed low at candidate 150 -> busy/done=0, best_dist=8'hFF immediately (async).
- Handshake (ZERO_EARLY_EXIT_EN defined): dist=0 at candidate 20 -> done on the next edge, early_exit=1; done held until ack; ack -> IDLE; without the macro the same stimulus gives done after 256 accepts with best_dist=0.
